// File: rtl/updown_counter_param.sv
// Up/down counter with prescaler, parallel load, wrap/saturate and LED bus.
// Define UPDN_COUNTER_EDGE_EN for one step per up/down press.
module updown_counter_param #(
  parameter int unsigned     WIDTH    = 8,
  parameter int unsigned     TICK_DIV = 100000000,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic [WIDTH-1:0]   load,
  input  logic               plN,
  input  logic               up,
  input  logic               down,
  input  logic               en,
  output logic [WIDTH-1:0]   count,
  output logic               tick,
  output logic               max_tc,
  output logic               min_tc,
  output logic               wrap,
  output logic [2*WIDTH-1:0] led
);

  localparam int unsigned PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];

  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             tick_raw;
  logic             up_s, dn_s;

`ifdef UPDN_COUNTER_EDGE_EN
  logic up_h_q, up_h_d;
  logic dn_h_q, dn_h_d;

  always_comb begin
    up_s   = up & ~up_h_q;
    dn_s   = down & ~dn_h_q;
    up_h_d = tick_raw ? up : up_h_q;
    dn_h_d = tick_raw ? down : dn_h_q;
  end
`else
  always_comb begin
    up_s = up;
    dn_s = down;
  end
`endif

  always_comb begin
    tick_raw = (pre_q == LAST);
    pre_d    = tick_raw ? '0 : pre_q + PW'(1);
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (tick_raw) begin
      if (!plN) begin
        cnt_d = (load > MAX_C) ? MAX_C : load;
      end else if (en && up_s && !dn_s) begin
        if (cnt_q < MAX_C) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else begin
          wrap_d = 1'b1;
          cnt_d  = SATURATE ? cnt_q : '0;
        end
      end else if (en && dn_s && !up_s) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          wrap_d = 1'b1;
          cnt_d  = SATURATE ? cnt_q : MAX_C;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
`ifdef UPDN_COUNTER_EDGE_EN
      up_h_q <= 1'b0;
      dn_h_q <= 1'b0;
`endif
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
`ifdef UPDN_COUNTER_EDGE_EN
      up_h_q <= up_h_d;
      dn_h_q <= dn_h_d;
`endif
    end
  end

  // tick is forced low while reset is held, even when TICK_DIV is 1
  assign tick   = rstN & tick_raw;
  assign count  = cnt_q;
  assign wrap   = wrap_q;
  assign max_tc = (cnt_q == MAX_C);
  assign min_tc = (cnt_q == '0);
  assign led    = {load, cnt_q};

endmodule
